wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order MEM/WB writeback and
//   results from long-latency units (divider, multi-cycle HI/LO moves). Sits after MEM/WB;
//   buffers late results in a small FIFO, grants the port each cycle, forces a WB stall when
//   buffered results starve, and drives the rf write port and debug_wb_* trace registers.
// PARAMETERS
//   FIFO_DEPTH    2   late-result FIFO entries (power of two, >=2)
//   STARVE_LIMIT  4   consecutive cycles a non-empty FIFO may lose before a forced grant (1..15)
// PORTS
//   clock              in   1   sole clock, rising edge
//   reset              in   1   asynchronous, active-low (`RESETABLE = 1'b0)
//   pipe_we            in   1   WB-stage write request (RegWriteW)
//   pipe_waddr         in   5   WB-stage destination (WriteRegW)
//   pipe_wdata         in   32  WB-stage result (muxed ALUOut/ReadData/Hilo/PC+8)
//   lc_valid           in   1   long-latency result valid
//   lc_ready           out  1   FIFO can accept; push when lc_valid & lc_ready
//   lc_waddr           in   5   long-latency destination
//   lc_wdata           in   32  long-latency result
//   stall_req          out  1   to hazard unit: hold WB stage this cycle
//   rf_we              out  1   register-file write enable
//   rf_waddr           out  5   register-file write address
//   rf_wdata           out  32  register-file write data
//   debug_wb_rf_wen    out  4   {4{rf_we}}
//   debug_wb_rf_wnum   out  5   = rf_waddr
//   debug_wb_rf_wdata  out  32  = rf_wdata
//   chk_addr_a/b       in   5   decode-stage source registers (rs, rt)
//   pend_hit           out  1   a source register has a buffered, unwritten result
// BEHAVIOUR
//   - Reset: rf_we=0, rf_waddr=0, rf_wdata=0, debug_* =0, stall_req=0, FIFO empty,
//     lc_ready=1, starve counter=0, state=ARB. Reset mid-operation discards FIFO contents.
//   - lc_ready = !fifo_full (no same-cycle pop-through when full).
//   - FSM, 2 states. ARB: grant pipe if pipe_we, else pop FIFO head if non-empty; counter
//     increments when FIFO non-empty and not granted, clears on any FIFO pop or empty FIFO;
//     counter==STARVE_LIMIT -> FORCE. FORCE: stall_req=1 (registered, first cycle of FORCE),
//     pipe inputs ignored (hazard unit holds them), FIFO head popped, counter cleared -> ARB.
//   - Grant-to-write latency 1 cycle: rf_* and debug_* register the granted request.
//   - Writes to $0 dropped: rf_we=0 next cycle, entry still consumed; lc pushes to $0 accepted
//     and discarded at pop.
//   - Simultaneous push+pop with 1 entry: both occur, count unchanged; push on empty FIFO is not
//     granted the same cycle (earliest write 2 cycles after push).
//   - FIFO order strictly preserved; pointers wrap modulo FIFO_DEPTH with extra wrap bit.
//   - Same-destination conflict: pipe write and buffered write to same reg are not reordered by
//     this block; ordering is the hazard unit's job via pend_hit.
// CONFIGURATION
//   WB_PENDING_CHECK_EN defined: pend_hit = OR over valid FIFO entries of
//     (waddr!=0 & (waddr==chk_addr_a | waddr==chk_addr_b)); combinational, includes an entry
//     popped this cycle. Undefined: comparators removed, pend_hit tied 0, ports kept.
// STRUCTURE
//   - defines.vh: `DATALENGTH, `R_SIZE, `RESETABLE, `ZEROWORD, state encodings WBA_ARB/WBA_FORCE.
//   - Sub-module wb_result_fifo (push/pop, full/empty, entry addr vector for pend_hit).
//   - Top: FSM, starve counter, grant mux, output registers.
// TESTING
//   1 reset low mid-stream with 2 buffered -> all outputs 0, lc_ready=1, no write after release.
//   2 pipe_we=1 addr 3 data 0x11 every cycle, lc push addr 7 data 0x22 at t0 -> stall_req at
//     t0+1+STARVE_LIMIT, rf write $7=0x22 next cycle, then pipe writes resume.
//   3 pipe idle, 2 lc pushes (5=0xA,6=0xB) -> rf writes $5 then $6 on consecutive cycles.
//   4 FIFO full (2 entries) with lc_valid held -> lc_ready=0, no entry lost or duplicated.
//   5 pipe_we=1 addr 0 data 0xFFFF -> rf_we=0, debug_wb_rf_wen=4'b0000.
//   6 macro on, entry addr 9 buffered, chk_addr_b=9 -> pend_hit=1; chk=0 with entry $0 -> 0.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the writeback port arbiter slice.
package wb_port_arbiter_pkg;

    localparam int DATALENGTH = 32;
    localparam int R_SIZE     = 5;
    localparam logic [DATALENGTH-1:0] ZEROWORD = '0;

    typedef enum logic {
        WBA_ARB   = 1'b0,
        WBA_FORCE = 1'b1
    } wba_state_e;

    typedef struct packed {
        logic [R_SIZE-1:0]     waddr;
        logic [DATALENGTH-1:0] wdata;
    } wb_req_t;

    // Register $0 is hard-wired; requests that target it never write.
    function automatic logic writes_reg(input logic [R_SIZE-1:0] waddr);
        return waddr != '0;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/long-latency producers and the writeback port arbiter.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  pipe_we;
    logic [R_SIZE-1:0]     pipe_waddr;
    logic [DATALENGTH-1:0] pipe_wdata;
    logic                  lc_valid;
    logic                  lc_ready;
    logic [R_SIZE-1:0]     lc_waddr;
    logic [DATALENGTH-1:0] lc_wdata;
    logic                  stall_req;
    logic                  rf_we;
    logic [R_SIZE-1:0]     rf_waddr;
    logic [DATALENGTH-1:0] rf_wdata;
    logic [3:0]            debug_wb_rf_wen;
    logic [R_SIZE-1:0]     debug_wb_rf_wnum;
    logic [DATALENGTH-1:0] debug_wb_rf_wdata;
    logic [R_SIZE-1:0]     chk_addr_a;
    logic [R_SIZE-1:0]     chk_addr_b;
    logic                  pend_hit;

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata, lc_valid, lc_waddr, lc_wdata,
               chk_addr_a, chk_addr_b,
        input  lc_ready, stall_req, rf_we, rf_waddr, rf_wdata,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, pend_hit
    );

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata, lc_valid, lc_waddr, lc_wdata,
               chk_addr_a, chk_addr_b,
        output lc_ready, stall_req, rf_we, rf_waddr, rf_wdata,
               debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, pend_hit
    );

endinterface

// File: rtl/wb_result_fifo.sv
// Late-result FIFO: wrap-bit pointers, head view, and per-entry live/address vectors.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic                         full,
    output logic                         empty,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [DEPTH-1:0][R_SIZE-1:0] entry_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    wb_req_t     mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, count;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_req;
    end

    // NOTE: outputs get a default first so no path through the block can infer a latch.
    always_comb begin
        entry_valid = '0;
        entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i]  = mem[i].waddr;
            entry_valid[i] = ({1'b0, AW'(i) - rd_ptr[AW-1:0]} < count);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants the single rf write port to MEM/WB or buffered late results.
// Optional WB_PENDING_CHECK_EN enables the pend_hit comparators (tied 0 otherwise).
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    wb_port_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wba_state_e                       state;
    logic [3:0]                       starve_cnt;
    logic                             fifo_full, fifo_empty, push, pop, grant_pipe;
    logic                             stall_q, rf_we_q, pend_hit;
    wb_req_t                          head, lc_req, rf_q;
    logic [FIFO_DEPTH-1:0]            entry_valid;
    logic [FIFO_DEPTH-1:0][R_SIZE-1:0] entry_addr;

    assign lc_req = '{waddr: bus.lc_waddr, wdata: bus.lc_wdata};
    assign push   = bus.lc_valid && !fifo_full;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (push),
        .push_req    (lc_req),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    // FORCE drains the head regardless of the pipe, whose inputs the hazard unit is holding.
    always_comb begin
        grant_pipe = 1'b0;
        pop        = 1'b0;
        if (state == WBA_FORCE)  pop        = !fifo_empty;
        else if (bus.pipe_we)    grant_pipe = 1'b1;
        else                     pop        = !fifo_empty;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= WBA_ARB;
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_q       <= '{waddr: '0, wdata: ZEROWORD};
        end else begin
            stall_q <= 1'b0;
            case (state)
                WBA_ARB: begin
                    if (fifo_empty || pop) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt == LIMIT) begin
                        state   <= WBA_FORCE;
                        stall_q <= 1'b1;
                    end else begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= WBA_ARB;
                    starve_cnt <= '0;
                end
            endcase

            if (grant_pipe) begin
                rf_we_q <= writes_reg(bus.pipe_waddr);
                rf_q    <= '{waddr: bus.pipe_waddr, wdata: bus.pipe_wdata};
            end else if (pop) begin
                rf_we_q <= writes_reg(head.waddr);
                rf_q    <= head;
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

`ifdef WB_PENDING_CHECK_EN
    always_comb begin
        pend_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && writes_reg(entry_addr[i]) &&
                (entry_addr[i] == bus.chk_addr_a || entry_addr[i] == bus.chk_addr_b))
                pend_hit = 1'b1;
        end
    end
`else
    logic unused_pend;
    assign unused_pend = ^{entry_valid, entry_addr, bus.chk_addr_a, bus.chk_addr_b};
    assign pend_hit    = 1'b0;
`endif

    assign bus.lc_ready          = !fifo_full;
    assign bus.stall_req         = stall_q;
    assign bus.rf_we             = rf_we_q;
    assign bus.rf_waddr          = rf_q.waddr;
    assign bus.rf_wdata          = rf_q.wdata;
    assign bus.debug_wb_rf_wen   = {4{rf_we_q}};
    assign bus.debug_wb_rf_wnum  = rf_q.waddr;
    assign bus.debug_wb_rf_wdata = rf_q.wdata;
    assign bus.pend_hit          = pend_hit;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;
`ifdef WB_PENDING_CHECK_EN
    localparam bit PEND_EN = 1'b1;
`else
    localparam bit PEND_EN = 1'b0;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: buffered results in arrival order, loss streak, forced-drain flag.
    ent_t        m_q[$];
    int          m_starve;
    bit          m_force, m_stall, m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_force  = 1'b0;
        m_stall  = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic model_edge(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                              input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bit   accept = lv && (m_q.size() < DEPTH);
        bit   had    = (m_q.size() != 0);
        bit   popped = 1'b0;
        ent_t e;
        m_we = 1'b0;
        if (m_force) begin
            if (had) begin
                e = m_q.pop_front();
                m_we = (e.a != 0); m_addr = e.a; m_data = e.d;
            end
            m_force = 1'b0; m_stall = 1'b0; m_starve = 0;
        end else begin
            m_stall = 1'b0;
            if (we) begin
                m_we = (wa != 0); m_addr = wa; m_data = wd;
            end else if (had) begin
                e = m_q.pop_front();
                popped = 1'b1;
                m_we = (e.a != 0); m_addr = e.a; m_data = e.d;
            end
            if (!had || popped)         m_starve = 0;
            else if (m_starve == LIMIT) begin m_force = 1'b1; m_stall = 1'b1; end
            else                        m_starve++;
        end
        if (accept) m_q.push_back('{a: la, d: ld});
    endtask

    function automatic bit model_pend(input logic [4:0] ca, input logic [4:0] cb);
        bit hit = 1'b0;
        foreach (m_q[i])
            if (m_q[i].a != 0 && (m_q[i].a == ca || m_q[i].a == cb)) hit = 1'b1;
        return hit && PEND_EN;
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model at the posedge, return at negedge.
    task automatic cycle(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bus.pipe_we = we; bus.pipe_waddr = wa; bus.pipe_wdata = wd;
        bus.lc_valid = lv; bus.lc_waddr = la; bus.lc_wdata = ld;
        @(posedge clock);
        model_edge(we, wa, wd, lv, la, ld);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr got %0d exp 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got %h exp 0", bus.rf_wdata); end
        checks++; if (bus.debug_wb_rf_wen !== 4'b0000) begin errors++; $display("FAIL reset_dbg_wen got %b exp 0000", bus.debug_wb_rf_wen); end
        checks++; if (bus.debug_wb_rf_wnum !== 5'd0) begin errors++; $display("FAIL reset_dbg_wnum got %0d exp 0", bus.debug_wb_rf_wnum); end
        checks++; if (bus.debug_wb_rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_dbg_wdata got %h exp 0", bus.debug_wb_rf_wdata); end
        checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall_req); end
        checks++; if (bus.lc_ready !== 1'b1) begin errors++; $display("FAIL reset_lc_ready got %b exp 1", bus.lc_ready); end
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL reset_pend_hit got %b exp 0", bus.pend_hit); end
    endtask

    task automatic test_drain_order();
        idle(2);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL drain_push_not_granted got %b exp 0", bus.rf_we); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'hB);
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hA}) begin
            errors++; $display("FAIL drain_first got we=%b a=%0d d=%h exp we=1 a=5 d=a", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        idle(1);
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd6, 32'hB}) begin
            errors++; $display("FAIL drain_second got we=%b a=%0d d=%h exp we=1 a=6 d=b", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        idle(1);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL drain_done got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_starvation();
        idle(2);
        for (int k = 0; k <= LIMIT + 3; k++) begin
            logic [4:0]  ea;
            logic [31:0] ed;
            cycle(1'b1, 5'd3, 32'h11, (k == 0), 5'd7, 32'h22);
            ea = (k == LIMIT + 2) ? 5'd7 : 5'd3;
            ed = (k == LIMIT + 2) ? 32'h22 : 32'h11;
            checks++; if (bus.stall_req !== (k == LIMIT + 1)) begin
                errors++; $display("FAIL starve_stall k=%0d got %b exp %b", k, bus.stall_req, (k == LIMIT + 1)); end
            checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, ea, ed}) begin
                errors++; $display("FAIL starve_write k=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                                   k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, ea, ed); end
        end
        idle(2);
    endtask

    task automatic test_full_backpressure();
        int idx = 0;
        idle(2);
        for (int k = 0; k < 4; k++) begin
            bit acc = bus.lc_ready;
            cycle(1'b1, 5'd1, 32'd1, 1'b1, 5'(10 + idx), 32'h100 + idx);
            if (acc) idx++;
            if (k >= 1) begin
                checks++; if (bus.lc_ready !== 1'b0) begin errors++; $display("FAIL full_lc_ready k=%0d got %b exp 0", k, bus.lc_ready); end
            end
        end
        idle(1);
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd10, 32'h100}) begin
            errors++; $display("FAIL full_drain0 got we=%b a=%0d d=%h exp we=1 a=10 d=100", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (bus.lc_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", bus.lc_ready); end
        idle(1);
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd11, 32'h101}) begin
            errors++; $display("FAIL full_drain1 got we=%b a=%0d d=%h exp we=1 a=11 d=101", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        idle(1);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL full_no_extra got %b exp 0", bus.rf_we); end
    endtask

    task automatic test_zero_dest();
        idle(2);
        cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_pipe_we got %b exp 0", bus.rf_we); end
        checks++; if (bus.debug_wb_rf_wen !== 4'b0000) begin errors++; $display("FAIL zero_pipe_dbg_wen got %b exp 0000", bus.debug_wb_rf_wen); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5);
        idle(1);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL zero_lc_pop_we got %b exp 0", bus.rf_we); end
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h12);
        idle(1);
        checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd12, 32'h12}) begin
            errors++; $display("FAIL zero_then_real got we=%b a=%0d d=%h exp we=1 a=12 d=12", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    endtask

    task automatic test_pend_hit();
        idle(2);
        bus.chk_addr_a = 5'd0; bus.chk_addr_b = 5'd9;
        cycle(1'b1, 5'd1, 32'd1, 1'b1, 5'd9, 32'h9);
        checks++; if (bus.pend_hit !== PEND_EN) begin errors++; $display("FAIL pend_buffered got %b exp %b", bus.pend_hit, PEND_EN); end
        cycle(1'b1, 5'd1, 32'd1, 1'b1, 5'd0, 32'h0);
        bus.chk_addr_a = 5'd0; bus.chk_addr_b = 5'd0; #1;
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL pend_zero_reg got %b exp 0", bus.pend_hit); end
        bus.chk_addr_a = 5'd9; bus.pipe_we = 1'b0; bus.lc_valid = 1'b0; #1;
        checks++; if (bus.pend_hit !== PEND_EN) begin errors++; $display("FAIL pend_popping got %b exp %b", bus.pend_hit, PEND_EN); end
        idle(1);
        checks++; if (bus.pend_hit !== 1'b0) begin errors++; $display("FAIL pend_after_pop got %b exp 0", bus.pend_hit); end
        idle(2);
        bus.chk_addr_a = 5'd0; bus.chk_addr_b = 5'd0;
    endtask

    task automatic test_random();
        idle(3);
        for (int n = 0; n < 400; n++) begin
            bit          we, lv;
            logic [4:0]  wa, la;
            logic [31:0] wd, ld;
            we = ($urandom_range(0, 99) < ((n < 200) ? 80 : 40));
            lv = ($urandom_range(0, 99) < 45);
            wa = 5'($urandom_range(0, 7)); wd = $urandom;
            la = 5'($urandom_range(0, 7)); ld = $urandom;
            bus.chk_addr_a = 5'($urandom_range(0, 7));
            bus.chk_addr_b = 5'($urandom_range(0, 7));
            #1;
            checks++; if (bus.pend_hit !== model_pend(bus.chk_addr_a, bus.chk_addr_b)) begin
                errors++; $display("FAIL rand_pend n=%0d got %b exp %b", n, bus.pend_hit, model_pend(bus.chk_addr_a, bus.chk_addr_b)); end
            cycle(we, wa, wd, lv, la, ld);
            checks++; if (bus.rf_we !== m_we) begin errors++; $display("FAIL rand_rf_we n=%0d got %b exp %b", n, bus.rf_we, m_we); end
            if (m_we) begin
                checks++; if ({bus.rf_waddr, bus.rf_wdata} !== {m_addr, m_data}) begin
                    errors++; $display("FAIL rand_rf_write n=%0d got a=%0d d=%h exp a=%0d d=%h", n, bus.rf_waddr, bus.rf_wdata, m_addr, m_data); end
                checks++; if ({bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata} !== {m_addr, m_data}) begin
                    errors++; $display("FAIL rand_dbg_write n=%0d got a=%0d d=%h exp a=%0d d=%h", n, bus.debug_wb_rf_wnum, bus.debug_wb_rf_wdata, m_addr, m_data); end
            end
            checks++; if (bus.debug_wb_rf_wen !== {4{m_we}}) begin errors++; $display("FAIL rand_dbg_wen n=%0d got %b exp %b", n, bus.debug_wb_rf_wen, {4{m_we}}); end
            checks++; if (bus.stall_req !== m_stall) begin errors++; $display("FAIL rand_stall n=%0d got %b exp %b", n, bus.stall_req, m_stall); end
            checks++; if (bus.lc_ready !== (m_q.size() < DEPTH)) begin
                errors++; $display("FAIL rand_lc_ready n=%0d got %b exp %b", n, bus.lc_ready, (m_q.size() < DEPTH)); end
        end
        bus.chk_addr_a = 5'd0; bus.chk_addr_b = 5'd0;
    endtask

    task automatic test_reset_midstream();
        idle(3);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd20, 32'h20);
        cycle(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21);
        bus.pipe_we = 1'b0; bus.lc_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        test_reset();
        @(negedge clock) reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1);
            checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL midreset_no_write k=%0d got %b exp 0", k, bus.rf_we); end
            checks++; if (bus.lc_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready k=%0d got %b exp 1", k, bus.lc_ready); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pipe_we = 1'b0; bus.pipe_waddr = '0; bus.pipe_wdata = '0;
        bus.lc_valid = 1'b0; bus.lc_waddr = '0; bus.lc_wdata = '0;
        bus.chk_addr_a = '0; bus.chk_addr_b = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle(1);
        test_reset();
        test_drain_order();
        test_starvation();
        test_full_backpressure();
        test_zero_dest();
        test_pend_hit();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
